lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
Data-side bus master between the core's load/store path and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the bus cycle and holds it through any number of wait states until ACKD_n is asserted.
- Returns lane-aligned, sign- or zero-extended load data over a valid/ready response channel.
- Generalises the current single-cycle data access: multi-cycle waits, width parameter, misalignment detection.

Parameters:
AW, 32, address width of req_addr and DAD.
DW, 32, data width of DDT/req_wdata/rsp_rdata; legal values 32 or 64.
TIMEOUT_CYCLES, 255, wait-state limit before abort; used only with BUS_TIMEOUT_EN.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-low.
req_valid  input  1  core request present.
req_ready  output  1  block can accept a request (high only in IDLE).
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 double (double legal only when DW=64).
req_signed  input  1  sign-extend a load result.
req_addr  input  AW  byte address.
req_wdata  input  DW  store data, right-aligned.
rsp_valid  output  1  response present.
rsp_ready  input  1  core accepts the response.
rsp_rdata  output  DW  extended load data; 0 for stores.
rsp_err  output  1  misaligned access or timeout.
DAD  output  AW  bus address.
DDT  inout  DW  bus data; driven only during a write cycle, high-Z otherwise.
MREQ  output  1  bus cycle active, active-high.
WRITE  output  1  bus write.
SIZE  output  2  bus size, same encoding as req_size.
ACKD_n  input  1  data acknowledge, active-low.

Behaviour:
- Reset (rst=0 at a rising edge) forces state IDLE with: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, wait counter 0.
- Reset mid-bus-cycle aborts it immediately; no response is produced.
- States:
  - IDLE → BUS on req_valid with an aligned address.
  - IDLE → RESP directly, with rsp_err=1, on req_valid with a misaligned address.
  - BUS → RESP when ACKD_n==0 is sampled.
  - RESP → IDLE when rsp_ready==1.
- Request handshake: accepted on the edge where req_valid & req_ready. Address, size, write flag, signed flag and wdata are registered at that edge.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0. A misaligned request produces no bus cycle; rsp_valid=1 on the cycle after acceptance.
- BUS state:
  - MREQ=1; DAD, SIZE and WRITE hold the registered values, stable for the whole cycle.
  - For a write, DDT carries the store data replicated into the lane at addr[log2(DW/8)-1:0]; little-endian, byte 0 is on DDT[7:0].
  - ACKD_n is sampled every edge. When ACKD_n==0, load data is captured from DDT, MREQ drops the next cycle and the state goes to RESP.
- Latency: accept at edge N; MREQ high from cycle N+1; ACKD_n sampled low at edge M gives rsp_valid high from cycle M+1. Minimum load-to-response is 2 cycles.
- Load extraction:
  - Select the lane by address offset.
  - req_signed=1 copies the top bit of the selected field into the upper bits; req_signed=0 fills the upper bits with zero.
  - A double in DW=64 needs no extension.
- RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready. req_ready=0, so at most one request is outstanding.
- ACKD_n low outside BUS is ignored.

Optional Feature:
BUS_TIMEOUT_EN.
- Defined: a wait counter runs in BUS. If ACKD_n is still high after TIMEOUT_CYCLES sampled edges, the block drops MREQ, goes to RESP with rsp_err=1 and rsp_rdata=0. An ACK on the same edge as the limit wins, giving a normal response.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package holds:
  - SIZE encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE.
  - FSM state constants: ST_IDLE, ST_BUS, ST_RESP.
- Sub-module lsu_lane_align: purely combinational write-lane replication and read-lane extract/extend. It is reused by the future I/O bus interface.

Test Plan:
- Load word 0x1000, ACKD_n low on the first BUS edge, DDT=0xDEADBEEF → rsp_valid 2 cycles after accept; rsp_rdata=0xDEADBEEF; rsp_err=0.
- Signed load byte 0x1003, DDT=0x80112233, 3 wait states → rsp_rdata=0xFFFFFF80 and MREQ high for exactly 4 cycles. Unsigned repeat → 0x00000080.
- Store half 0x2002, wdata=0x0000ABCD → DDT=0xABCDABCD, WRITE=1, SIZE=01 while MREQ is high; DDT high-Z after ACK.
- Load word 0x1001 → no MREQ pulse; rsp_err=1 on the next cycle.
- Hold rsp_ready=0 for 5 cycles → response stays stable; req_ready=0; a new req_valid is not accepted.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ACKD_n held high → rsp_err=1 after 4 BUS cycles. Separately, rst=0 mid-BUS → MREQ=0 and IDLE next cycle.

Source files
------------

// File: rtl/lsu_bus_if_pkg.sv
// ---------------------------------------------------------------------------
// lsu_bus_if_pkg
// Shared definitions for the data-side bus master (lsu_bus_if) and its lane
// alignment helper (lsu_lane_align).
//   - SZ_* : access size encoding, used on req_size and on the SIZE bus pins
//   - state_t : FSM states of the bus master
//   - is_aligned() : natural-alignment test for an access size
//   - size_bits()  : field width in bits for an access size
// ---------------------------------------------------------------------------
package lsu_bus_if_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // An access is aligned when the low address bits below its size are zero.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo[1:0] == 2'b00);
      default: return (lo == 3'b000);
    endcase
  endfunction

  function automatic int size_bits(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 8;
      SZ_HALF: return 16;
      SZ_WORD: return 32;
      default: return 64;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for a little-endian data bus.
// Write side: replicates the right-aligned store field across every lane of
// the bus, so whichever lane the address selects carries the data.
// Read side: shifts the addressed lane down to bit 0 and sign- or
// zero-extends it to the full data width.
// Ports:
//   i_size      access size (SZ_* encoding)
//   i_offset    byte offset of the access within the bus word
//   i_signed    sign-extend the read field
//   i_wdata     right-aligned store data
//   i_bus_rdata raw data sampled from the bus
//   o_bus_wdata lane-replicated data to drive onto the bus
//   o_rdata     extracted and extended load result
// ---------------------------------------------------------------------------
module lsu_lane_align
  import lsu_bus_if_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]               i_size,
  input  logic [$clog2(DW/8)-1:0]  i_offset,
  input  logic                     i_signed,
  input  logic [DW-1:0]            i_wdata,
  input  logic [DW-1:0]            i_bus_rdata,
  output logic [DW-1:0]            o_bus_wdata,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] w_shift;
  logic          w_msb;
  logic          w_fill;
  int            w_bits;

  // Replication counts are all at least one because DW is 32 or 64.
  always_comb begin
    o_bus_wdata = i_wdata;
    case (i_size)
      SZ_BYTE: o_bus_wdata = {(DW/8){i_wdata[7:0]}};
      SZ_HALF: o_bus_wdata = {(DW/16){i_wdata[15:0]}};
      SZ_WORD: o_bus_wdata = {(DW/32){i_wdata[31:0]}};
      default: o_bus_wdata = i_wdata;
    endcase
  end

  always_comb begin
    w_shift = i_bus_rdata >> {i_offset, 3'b000};
    w_bits  = size_bits(i_size);
    if (w_bits > DW) begin
      w_bits = DW;
    end
    case (i_size)
      SZ_BYTE: w_msb = w_shift[7];
      SZ_HALF: w_msb = w_shift[15];
      SZ_WORD: w_msb = w_shift[31];
      default: w_msb = w_shift[DW-1];
    endcase
    w_fill  = i_signed & w_msb;
    o_rdata = '0;
    for (int i = 0; i < DW; i++) begin
      o_rdata[i] = (i < w_bits) ? w_shift[i] : w_fill;
    end
  end

endmodule

// File: rtl/lsu_bus_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_if
// Data-side bus master between the core load/store path and the external
// data bus. One request is accepted at a time; the bus cycle is held through
// any number of wait states until ACKD_n is sampled low, then the extracted
// and extended load data (or zero for stores) is returned on the response
// channel. Misaligned requests skip the bus and respond with rsp_err=1.
//
// Build option: define BUS_TIMEOUT_EN to abort a bus cycle that sees no
// acknowledge within TIMEOUT_CYCLES sampled edges (rsp_err=1, rsp_rdata=0).
// Without it the bus cycle waits indefinitely.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 double (DW=64 only)
//   req_signed          sign-extend load result
//   req_addr, req_wdata byte address, right-aligned store data
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  extended load data (0 for stores), error flag
//   DAD, DDT            bus address, bidirectional bus data
//   MREQ, WRITE, SIZE   bus cycle strobe, direction, size
//   ACKD_n              bus data acknowledge, active-low
// ---------------------------------------------------------------------------
module lsu_bus_if
  import lsu_bus_if_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] DAD,
  inout  wire  [DW-1:0] DDT,
  output logic          MREQ,
  output logic          WRITE,
  output logic [1:0]    SIZE,
  input  logic          ACKD_n
);

  localparam int OW = $clog2(DW/8);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_size;
  logic          r_write;
  logic          r_signed;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic          w_misalign;
  logic          w_accept;
  logic          w_ack;
  logic          w_tmo;
  logic [DW-1:0] w_wlane;
  logic [DW-1:0] w_rext;

  // A double access does not exist on a 32-bit bus, so it is rejected the
  // same way as a misaligned one.
  assign w_misalign = ~is_aligned(req_size, req_addr[2:0]) |
                      ((DW < 64) && (req_size == SZ_DOUBLE));
  assign w_accept   = req_valid & (r_state == ST_IDLE);
  assign w_ack      = (r_state == ST_BUS) & ~ACKD_n;

`ifdef BUS_TIMEOUT_EN
  // Counts sampled edges without acknowledge; the abort fires on the edge
  // that would be the TIMEOUT_CYCLES-th one, unless ACKD_n is low there.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_cnt;

  assign w_tmo = (r_state == ST_BUS) & ACKD_n & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  // The limit only matters with the timeout build; keep it referenced.
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next = w_misalign ? ST_RESP : ST_BUS;
        end
      end
      ST_BUS: begin
        if (w_ack || w_tmo) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ---- request capture and response data ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr   <= '0;
      r_size   <= SZ_BYTE;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_size   <= req_size;
      r_write  <= req_write;
      r_signed <= req_signed;
      r_wdata  <= req_wdata;
      r_rdata  <= '0;
      r_err    <= w_misalign;
    end else if (w_ack) begin
      r_rdata  <= r_write ? '0 : w_rext;
      r_err    <= 1'b0;
    end else if (w_tmo) begin
      r_rdata  <= '0;
      r_err    <= 1'b1;
    end
  end

  lsu_lane_align #(
    .DW (DW)
  ) u_lane (
    .i_size      (r_size),
    .i_offset    (r_addr[OW-1:0]),
    .i_signed    (r_signed),
    .i_wdata     (r_wdata),
    .i_bus_rdata (DDT),
    .o_bus_wdata (w_wlane),
    .o_rdata     (w_rext)
  );

  // ---- outputs ----
  // Bus pins are qualified by MREQ so the bus is quiet outside a cycle.
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign MREQ      = (r_state == ST_BUS);
  assign DAD       = MREQ ? r_addr : '0;
  assign WRITE     = MREQ & r_write;
  assign SIZE      = MREQ ? r_size : SZ_BYTE;
  assign DDT       = (MREQ && r_write) ? w_wlane : {DW{1'bz}};

endmodule

// File: tb/tb_lsu_bus_if.sv
module tb_lsu_bus_if;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] DAD;
  wire  [DW-1:0] DDT;
  logic          MREQ;
  logic          WRITE;
  logic [1:0]    SIZE;
  logic          ACKD_n;

  logic          tb_oe;
  logic [DW-1:0] tb_dat;
  assign DDT = tb_oe ? tb_dat : {DW{1'bz}};

  always #5 clk = ~clk;

  lsu_bus_if #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .DAD(DAD), .DDT(DDT), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .ACKD_n(ACKD_n)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          mreq;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // bus responder configuration and bus expectations
  int          waits = 0;
  logic [31:0] rd_data = '0;
  bit          ack_force = 1'b0;
  bit          e_bus = 1'b0;
  logic [31:0] e_dad = '0;
  logic        e_write = 1'b0;
  logic [1:0]  e_size = 2'b00;
  logic [31:0] e_ddt = '0;

  int cyc = 0;
  int acc_cyc = 0;
  int mreq_cnt = 0;
  int rsp_lat = 0;
  bit rsp_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h required %08h", nm, act, req);
    end
  endtask

  // Memory-side responder: acknowledges after 'waits' wait states.
  initial begin
    int bcnt;
    bcnt   = 0;
    ACKD_n = 1'b1;
    tb_oe  = 1'b0;
    tb_dat = '0;
    forever begin
      @(posedge clk);
      #1;
      if (MREQ) begin
        ACKD_n = (bcnt == waits) ? 1'b0 : 1'b1;
        tb_oe  = !WRITE;
        tb_dat = rd_data;
        bcnt++;
      end else begin
        ACKD_n = !ack_force;
        tb_oe  = 1'b0;
        bcnt   = 0;
      end
    end
  end

  // Monitor: bus-cycle checks and scoreboard pops on response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (req_valid && req_ready) begin
        acc_cyc  = cyc;
        mreq_cnt = 0;
        rsp_seen = 1'b0;
      end
      if (MREQ) begin
        mreq_cnt++;
        chk("mreq_allowed", 32'(e_bus), 32'd1);
        chk("bus_dad", DAD, e_dad);
        chk("bus_write", 32'(WRITE), 32'(e_write));
        chk("bus_size", 32'(SIZE), 32'(e_size));
        if (e_write) chk("bus_ddt", DDT, e_ddt);
      end
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1'b1;
        rsp_lat  = cyc - acc_cyc;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_pending", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(rsp_lat), 32'(e.lat));
          chk("mreq_cycles", 32'(mreq_cnt), 32'(e.mreq));
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdat, input int w, input bit push,
                       input logic [31:0] x_rdata, input bit x_err,
                       input int x_lat, input int x_mreq, input logic [31:0] x_ddt);
    bit acc;
    int n;
    @(posedge clk);
    #1;
    waits   = w;
    rd_data = rdat;
    e_bus   = (x_mreq != 0);
    e_dad   = addr;
    e_write = wr;
    e_size  = sz;
    e_ddt   = x_ddt;
    if (push) sb.push_back('{x_rdata, x_err, x_lat, x_mreq});
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    chk("accept", 32'(acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("done_in_time", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    e_bus = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_size", 32'(SIZE), 32'd0);
    chk("rst_dad", DAD, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // wr  size   sg  addr          wdata         bus data      w  push rdata        err lat mreq ddt
    issue(0, 2'b10, 0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 0, 2, 1, 32'h0);
    wait_done();
    issue(0, 2'b00, 1, 32'h0000_1003, 32'h0, 32'h8011_2233, 3, 1, 32'hFFFF_FF80, 0, 5, 4, 32'h0);
    wait_done();
    issue(0, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h8011_2233, 3, 1, 32'h0000_0080, 0, 5, 4, 32'h0);
    wait_done();
    issue(1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1, 1, 32'h0, 0, 3, 2, 32'hABCD_ABCD);
    wait_done();
    issue(0, 2'b10, 0, 32'h0000_1001, 32'h0, 32'h1111_1111, 0, 1, 32'h0, 1, 1, 0, 32'h0);
    wait_done();
    issue(0, 2'b01, 1, 32'h0000_1003, 32'h0, 32'h1111_1111, 0, 1, 32'h0, 1, 1, 0, 32'h0);
    wait_done();
    issue(0, 2'b01, 1, 32'h0000_1002, 32'h0, 32'h7FFF_1234, 0, 1, 32'h0000_7FFF, 0, 2, 1, 32'h0);
    wait_done();
    issue(0, 2'b01, 0, 32'h0000_1000, 32'h0, 32'h1234_ABCD, 0, 1, 32'h0000_ABCD, 0, 2, 1, 32'h0);
    wait_done();
    issue(0, 2'b01, 1, 32'h0000_1000, 32'h0, 32'h1234_ABCD, 0, 1, 32'hFFFF_ABCD, 0, 2, 1, 32'h0);
    wait_done();
    issue(1, 2'b00, 0, 32'h0000_2001, 32'h0000_005A, 32'h0, 2, 1, 32'h0, 0, 4, 3, 32'h5A5A_5A5A);
    wait_done();
    issue(1, 2'b10, 0, 32'h0000_2004, 32'h1234_5678, 32'h0, 0, 1, 32'h0, 0, 2, 1, 32'h1234_5678);
    wait_done();
    issue(0, 2'b10, 1, 32'h0000_1008, 32'h0, 32'h8000_0001, 0, 1, 32'h8000_0001, 0, 2, 1, 32'h0);
    wait_done();

    // response back-pressure with a competing request
    rsp_ready = 1'b0;
    issue(0, 2'b01, 1, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 0, 1, 32'hFFFF_8001, 0, 2, 1, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hFFFF_8001);
      chk("hold_rsp_err", 32'(rsp_err), 32'd0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_mreq", 32'(MREQ), 32'd0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done();

    // acknowledge asserted while idle is ignored
    ack_force = 1'b1;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ack_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_ack_req_ready", 32'(req_ready), 32'd1);
    end
    ack_force = 1'b0;
    repeat (2) @(posedge clk);
    issue(0, 2'b10, 0, 32'h0000_100C, 32'h0, 32'hCAFE_F00D, 2, 1, 32'hCAFE_F00D, 0, 4, 3, 32'h0);
    wait_done();

    // reset in the middle of a bus cycle
    issue(0, 2'b10, 0, 32'h0000_4000, 32'h0, 32'h5555_5555, 1000, 0, 32'h0, 0, 0, 1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    e_bus = 1'b0;
    @(negedge clk);
    chk("midrst_mreq", 32'(MREQ), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    issue(0, 2'b10, 0, 32'h0000_1000, 32'h0, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 0, 2, 1, 32'h0);
    wait_done();

`ifdef BUS_TIMEOUT_EN
    // no acknowledge: abort after 4 sampled edges
    issue(0, 2'b10, 0, 32'h0000_5000, 32'h0, 32'h7777_7777, 1000, 1, 32'h0, 1, 5, 4, 32'h0);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
